// File: rtl/instruction_ram_loader_pkg.sv
// Shared types and constants for the instruction RAM boot loader.
// The INSTR_LOADER_VERIFY_EN build adds a read-back verify pass after the load.
package instruction_ram_loader_pkg;

    localparam int RAM_DEPTH      = 8192;
    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_WRITE      = 3'd2,
        S_VERIFY_RD  = 3'd3,
        S_VERIFY_CMP = 3'd4,
        S_DONE       = 3'd5,
        S_ERROR      = 3'd6
    } loader_state_t;

endpackage

// File: rtl/instruction_ram_loader_word_assembler.sv
// Packs the little-endian byte stream into 32-bit words; o_word_valid marks
// the cycle the 4th byte is accepted, with o_word already holding that byte.
module loader_word_assembler
    import instruction_ram_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [BCNT_W-1:0] r_cnt;
    logic [31:0]       r_shift;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_byte_valid) begin
            r_cnt   <= r_cnt + 1'b1;
            r_shift <= {i_byte, r_shift[31:8]};
        end
    end

    // Earlier bytes shift down, so byte 0 lands in [7:0] once the word completes.
    assign o_word       = {i_byte, r_shift[31:8]};
    assign o_word_valid = i_byte_valid && (r_cnt == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_ram_loader.sv
// Boot-time loader: streams bytes into the instruction RAM s2 port, holding the CPU in reset.
// Define INSTR_LOADER_VERIFY_EN to read back and sum-check the image before releasing the CPU.
module instruction_ram_loader
    import instruction_ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = RAM_DEPTH,
    parameter int LEN_WIDTH  = 14
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [LEN_WIDTH-1:0]  i_length_words,
    input  logic                  i_s_valid,
    input  logic [7:0]            i_s_data,
    output logic                  o_s_ready,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic                  o_ram_chipselect,
    output logic                  o_ram_write,
    output logic [3:0]            o_ram_byteenable,
    output logic [31:0]           o_ram_writedata,
    output logic                  o_ram_debugaccess,
    input  logic [31:0]           i_ram_readdata,
    output logic                  o_cpu_reset_req,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [31:0]           o_checksum
);

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(DEPTH);

    loader_state_t         r_state;
    logic                  r_s_ready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic                  r_cs;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [31:0]           r_wd;
    logic                  r_dbg;
    logic                  r_cpu_rst;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [31:0]           r_checksum;

    logic                  w_fire;
    logic [31:0]           w_word;
    logic                  w_word_valid;

`ifdef INSTR_LOADER_VERIFY_EN
    logic [31:0]           r_rd_sum;
`else
    logic                  w_unused_rd;
    assign w_unused_rd = ^i_ram_readdata;
`endif

    // A simultaneous abort wins over the byte, so the byte is not consumed.
    assign w_fire = r_s_ready && i_s_valid && !i_abort;

    loader_word_assembler u_asm (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clear      (!r_busy),
        .i_byte_valid (w_fire),
        .i_byte       (i_s_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_s_ready   <= 1'b0;
            r_addr      <= '0;
            r_last_addr <= '0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= 4'h0;
            r_wd        <= '0;
            r_dbg       <= 1'b0;
            r_cpu_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_checksum  <= '0;
`ifdef INSTR_LOADER_VERIFY_EN
            r_rd_sum    <= '0;
`endif
        end else begin
            r_cs  <= 1'b0;
            r_we  <= 1'b0;
            r_dbg <= 1'b0;
            r_be  <= 4'h0;
            if (i_abort && r_busy) begin
                r_state   <= S_ERROR;
                r_s_ready <= 1'b0;
                r_busy    <= 1'b0;
                r_error   <= 1'b1;
                r_cpu_rst <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (i_start) begin
                            r_done    <= 1'b0;
                            r_error   <= 1'b0;
                            r_cpu_rst <= 1'b1;
                            if (i_length_words == '0) begin
                                r_state   <= S_DONE;
                                r_done    <= 1'b1;
                                r_cpu_rst <= 1'b0;
                            end else if (i_length_words > LEN_MAX) begin
                                r_state <= S_ERROR;
                                r_error <= 1'b1;
                            end else begin
                                r_state     <= S_LOAD;
                                r_s_ready   <= 1'b1;
                                r_busy      <= 1'b1;
                                r_checksum  <= '0;
                                r_addr      <= '0;
                                r_last_addr <= ADDR_WIDTH'(i_length_words - 1'b1);
                            end
                        end
                    end
                    S_LOAD: begin
                        if (w_word_valid) begin
                            r_state   <= S_WRITE;
                            r_s_ready <= 1'b0;
                            r_cs      <= 1'b1;
                            r_we      <= 1'b1;
                            r_dbg     <= 1'b1;
                            r_be      <= 4'hF;
                            r_wd      <= w_word;
                        end
                    end
                    S_WRITE: begin
                        r_checksum <= r_checksum + r_wd;
                        if (r_addr == r_last_addr) begin
                            r_addr <= '0;
`ifdef INSTR_LOADER_VERIFY_EN
                            r_state  <= S_VERIFY_RD;
                            r_cs     <= 1'b1;
                            r_rd_sum <= '0;
`else
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                            r_busy    <= 1'b0;
`endif
                        end else begin
                            r_addr    <= r_addr + 1'b1;
                            r_state   <= S_LOAD;
                            r_s_ready <= 1'b1;
                        end
                    end
`ifdef INSTR_LOADER_VERIFY_EN
                    S_VERIFY_RD: begin
                        r_state <= S_VERIFY_CMP;
                    end
                    // Read data for the address presented in VERIFY_RD arrives here.
                    S_VERIFY_CMP: begin
                        r_rd_sum <= r_rd_sum + i_ram_readdata;
                        if (r_addr == r_last_addr) begin
                            r_busy <= 1'b0;
                            r_addr <= '0;
                            if (r_rd_sum + i_ram_readdata == r_checksum) begin
                                r_state   <= S_DONE;
                                r_done    <= 1'b1;
                                r_cpu_rst <= 1'b0;
                            end else begin
                                r_state <= S_ERROR;
                                r_error <= 1'b1;
                            end
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_VERIFY_RD;
                            r_cs    <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        r_state   <= S_IDLE;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b0;
                        r_cpu_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_s_ready         = r_s_ready;
    assign o_ram_address     = r_addr;
    assign o_ram_chipselect  = r_cs;
    assign o_ram_write       = r_we;
    assign o_ram_byteenable  = r_be;
    assign o_ram_writedata   = r_wd;
    assign o_ram_debugaccess = r_dbg;
    assign o_cpu_reset_req   = r_cpu_rst;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_error           = r_error;
    assign o_checksum        = r_checksum;

endmodule
